// File: rtl/data_memory_lsu.sv
// Byte-addressed word RAM for the MEM stage: valid/ready request port, fixed-latency
// in-order responses, sign-correct sub-word access and per-request fault reporting.
module data_memory_lsu #(
  parameter int DEPTH       = 2048,
  parameter int LAT         = 2,
  parameter int INIT_OFFSET = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_fault,
  output logic [1:0]  rsp_cause,
  output logic        init_done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   init_idx_q, init_idx_d;
  logic [31:0]     mem_q [DEPTH];

  logic [LAT-1:0]  pv_q, pv_d;
  logic [LAT-1:0]  pfault_q, pfault_d;
  logic [31:0]     pdata_q [LAT];
  logic [31:0]     pdata_d [LAT];
  logic [1:0]      pcause_q [LAT];
  logic [1:0]      pcause_d [LAT];

  logic            accept;
  logic [AW-1:0]   word;
  logic [1:0]      off;
  logic [31:0]     rd_word;
  logic            illegal, misal, oor;
  logic [1:0]      cause;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_data;

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [31:0]     mem_wdata;
  logic [3:0]      mem_be;

  assign req_ready = (state_q == ST_RUN);
  assign init_done = (state_q == ST_RUN);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    if (state_q == ST_INIT) begin
      init_idx_d = init_idx_q + AW'(1);
      if (init_idx_q == AW'(DEPTH - 1)) state_d = ST_RUN;
    end
  end

  // Decode and fault classification; illegal funct3 outranks misalignment outranks range.
  always_comb begin
    word    = req_addr[AW+1:2];
    off     = req_addr[1:0];
    rd_word = mem_q[word];
    oor     = ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
    illegal = req_write ? (req_funct3 > 3'd2)
                        : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11);
    misal   = (req_funct3[1:0] == 2'b01 && off[0]) ||
              (req_funct3[1:0] == 2'b10 && off != 2'b00);
    if (illegal)    cause = 2'd3;
    else if (misal) cause = 2'd1;
    else if (oor)   cause = 2'd2;
    else            cause = 2'd0;

    ld_byte = 8'(rd_word >> {off, 3'b000});
    ld_half = off[1] ? rd_word[31:16] : rd_word[15:0];
    case (req_funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b101:  ld_data = {16'b0, ld_half};
      default: ld_data = '0;
    endcase
  end

  // The fill owns the write port until RUN; afterwards only non-faulting stores use it.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = word;
    mem_wdata = req_wdata;
    mem_be    = 4'b1111;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_idx_q;
      mem_wdata = 32'(init_idx_q) + 32'(INIT_OFFSET);
    end else begin
      mem_we = accept && req_write && (cause == 2'd0);
      case (req_funct3[1:0])
        2'b00: begin
          mem_be    = 4'b0001 << off;
          mem_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          mem_be    = off[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = req_wdata;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (mem_be[i]) mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Bubbles carry zeros so the outputs read 0 whenever rsp_valid is low.
  always_comb begin
    pv_d[0]     = accept;
    pfault_d[0] = accept && (cause != 2'd0);
    pcause_d[0] = accept ? cause : 2'd0;
    pdata_d[0]  = (accept && !req_write && cause == 2'd0) ? ld_data : '0;
    for (int unsigned i = 1; i < LAT; i++) begin
      pv_d[i]     = pv_q[i-1];
      pfault_d[i] = pfault_q[i-1];
      pcause_d[i] = pcause_q[i-1];
      pdata_d[i]  = pdata_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
      pv_q       <= '0;
      pfault_q   <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        pdata_q[i]  <= '0;
        pcause_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      pv_q       <= pv_d;
      pfault_q   <= pfault_d;
      for (int unsigned i = 0; i < LAT; i++) begin
        pdata_q[i]  <= pdata_d[i];
        pcause_q[i] <= pcause_d[i];
      end
    end
  end

  assign rsp_valid = pv_q[LAT-1];
  assign rsp_fault = pfault_q[LAT-1];
  assign rsp_data  = pdata_q[LAT-1];
  assign rsp_cause = pcause_q[LAT-1];

endmodule
